// File: rtl/y86_pkg.sv
// Shared Y86 memory-stage constants: icodes, status codes, wait-FSM state.
package y86_pkg;

  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  function automatic logic is_rd(input logic [3:0] ic);
    return (ic == MRMOVQ) || (ic == RET) || (ic == POPQ);
  endfunction

  function automatic logic is_wr(input logic [3:0] ic);
    return (ic == RMMOVQ) || (ic == PUSHQ) || (ic == CALL);
  endfunction

endpackage

// File: rtl/mem_stage_wait_if.sv
// Memory-stage bus: M_* from the execute/memory register, m_* back out.
interface mem_stage_wait_if #(parameter int DATA_W = 64);
  logic [1:0]        M_stat;
  logic [3:0]        M_icode;
  logic [63:0]       M_valA;
  logic [63:0]       M_valE;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
  logic [3:0]        m_icode;
  logic [63:0]       m_valE;
  logic [3:0]        m_dstE;
  logic [3:0]        m_dstM;
  logic [DATA_W-1:0] m_valM;
  logic [1:0]        m_stat;
  logic              m_stall;

  modport master (
    output M_stat, M_icode, M_valA, M_valE, M_dstE, M_dstM,
    input  m_icode, m_valE, m_dstE, m_dstM, m_valM, m_stat, m_stall
  );

  modport slave (
    input  M_stat, M_icode, M_valA, M_valE, M_dstE, M_dstM,
    output m_icode, m_valE, m_dstE, m_dstM, m_valM, m_stat, m_stall
  );
endinterface

// File: rtl/mem_stage_wait_dmem_array.sv
// Byte-addressed data array: one little-endian word write port, one
// combinational word read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int MEM_SIZE   = 512,
  parameter int WORD_BYTES = 8,
  parameter int AW         = $clog2(MEM_SIZE)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [8*WORD_BYTES-1:0] rdata
);

  logic [7:0] mem [MEM_SIZE];

  // word write: byte lane i lands at waddr+i (lowest byte at lowest address)
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) mem[waddr + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  for (genvar b = 0; b < WORD_BYTES; b++) begin : g_lane
    assign rdata[8*b +: 8] = mem[raddr + AW'(b)];
  end

endmodule

// File: rtl/mem_stage_wait.sv
// Y86 memory stage with a programmable number of wait states. An accepted
// access stalls upstream until its completion cycle; writes commit on the
// edge that ends that cycle, reads are combinational from the array.
module mem_stage_wait #(
  parameter int MEM_SIZE    = 512,
  parameter int WORD_BYTES  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_stage_wait_if.slave  bus
);
  import y86_pkg::*;

  localparam int          DATA_W   = 8 * WORD_BYTES;
  localparam int          AW       = $clog2(MEM_SIZE);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_SIZE - WORD_BYTES);
  localparam logic [3:0]  WS       = 4'(WAIT_STATES);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              rd, wr, is_mem, in_range, go, done, we;
  logic [63:0]       addr;
  logic [DATA_W-1:0] rdata;

  // decode: ret/popq read through valA, everything else addresses via valE
  always_comb begin
    rd       = is_rd(bus.M_icode);
    wr       = is_wr(bus.M_icode);
    is_mem   = rd | wr;
    addr     = (bus.M_icode == RET || bus.M_icode == POPQ) ? bus.M_valA : bus.M_valE;
    in_range = (addr <= ADDR_MAX);
    go       = (bus.M_stat == AOK) && is_mem && in_range;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state: count wait cycles 1..WAIT_STATES, then back to IDLE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (go && WAIT_STATES != 0) begin
        state_nx = WAIT;
        cnt_nx   = 4'd1;
      end
      WAIT: if (cnt == WS) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 4'd1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // outputs: stall until completion; reset forces stall/data low
  always_comb begin
    done        = (state == WAIT) ? (cnt == WS) : (WAIT_STATES == 0);
    bus.m_stall = rst_n && ((state == WAIT) ? (cnt != WS) : (go && WAIT_STATES != 0));
    we          = rst_n && go && wr && done;
    bus.m_valM  = (rst_n && go && rd && done) ? rdata : '0;
    if (!rst_n || bus.M_stat != AOK) bus.m_stat = bus.M_stat;
    else if (is_mem && !in_range)    bus.m_stat = ADR;
    else                             bus.m_stat = AOK;
  end

  assign bus.m_icode = bus.M_icode;
  assign bus.m_valE  = bus.M_valE;
  assign bus.m_dstE  = bus.M_dstE;
  assign bus.m_dstM  = bus.M_dstM;

  dmem_array #(.MEM_SIZE(MEM_SIZE), .WORD_BYTES(WORD_BYTES), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (addr[AW-1:0]),
    .wdata (bus.M_valA[DATA_W-1:0]),
    .raddr (addr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench: three configurations (0 waits, 3 waits, 4-byte words).
module tb_mem_stage_wait;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n;
  logic stall0_seen = 1'b0;

  mem_stage_wait_if #(.DATA_W(64)) b0();
  mem_stage_wait_if #(.DATA_W(64)) b3();
  mem_stage_wait_if #(.DATA_W(32)) b4();

  mem_stage_wait #(.MEM_SIZE(512), .WORD_BYTES(8), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  mem_stage_wait #(.MEM_SIZE(512), .WORD_BYTES(8), .WAIT_STATES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  mem_stage_wait #(.MEM_SIZE(512), .WORD_BYTES(4), .WAIT_STATES(0)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  always @(negedge clk) if (b0.m_stall === 1'b1) stall0_seen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
    b0.M_stat = st; b0.M_icode = ic; b0.M_valA = va; b0.M_valE = ve; b0.M_dstE = 4'h3; b0.M_dstM = 4'h7;
  endtask

  task automatic drv3(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
    b3.M_stat = st; b3.M_icode = ic; b3.M_valA = va; b3.M_valE = ve; b3.M_dstE = 4'h3; b3.M_dstM = 4'h7;
  endtask

  task automatic drv4(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve);
    b4.M_stat = st; b4.M_icode = ic; b4.M_valA = va; b4.M_valE = ve; b4.M_dstE = 4'h3; b4.M_dstM = 4'h7;
  endtask

  // counts cycles with m_stall high on the 3-wait instance, bounded
  task automatic wait3(output int cyc);
    cyc = 0;
    while (b3.m_stall === 1'b1 && cyc < 20) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drv0(AOK, 4'h1, 64'h0, 64'h0);
    drv3(AOK, MRMOVQ, 64'h0, 64'h100);
    drv4(AOK, 4'h1, 64'h0, 64'h0);
    #2;
    chk("rst_stall", 64'(b3.m_stall), 64'h0);
    chk("rst_valM",  b3.m_valM, 64'h0);
    chk("rst_state", 64'(u3.state), 64'(IDLE));
    drv3(HLT, MRMOVQ, 64'h0, 64'h100);
    #1;
    chk("rst_stat", 64'(b3.m_stat), 64'(HLT));
    drv3(AOK, 4'h1, 64'h0, 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;

    // ---- zero wait states ----
    drv0(AOK, RMMOVQ, 64'h1122334455667788, 64'h40);
    #1;
    chk("a_wr_stall", 64'(b0.m_stall), 64'h0);
    chk("a_wr_stat",  64'(b0.m_stat), 64'(AOK));
    tick();
    chk("a_byte40", 64'(u0.u_mem.mem[64]), 64'h88);
    chk("a_byte47", 64'(u0.u_mem.mem[71]), 64'h11);
    drv0(AOK, MRMOVQ, 64'h0, 64'h40);
    #1;
    chk("a_rd",         b0.m_valM, 64'h1122334455667788);
    chk("a_pass_valE",  b0.m_valE, 64'h40);
    chk("a_pass_icode", 64'(b0.m_icode), 64'h5);
    chk("a_pass_dst",   64'({b0.m_dstE, b0.m_dstM}), 64'h37);
    drv0(AOK, RET, 64'h40, 64'h1F8);
    #1;
    chk("a_ret", b0.m_valM, 64'h1122334455667788);
    drv0(AOK, PUSHQ, 64'hA5A5_0F0F_3C3C_9696, 64'h80);
    tick();
    drv0(AOK, POPQ, 64'h80, 64'h0);
    #1;
    chk("a_pop", b0.m_valM, 64'hA5A5_0F0F_3C3C_9696);
    drv0(AOK, RMMOVQ, 64'h0, 64'd504);
    #1;
    chk("a_504_stat", 64'(b0.m_stat), 64'(AOK));
    tick();
    drv0(AOK, MRMOVQ, 64'h0, 64'd505);
    #1;
    chk("a_505_stat", 64'(b0.m_stat), 64'(ADR));
    chk("a_505_valM", b0.m_valM, 64'h0);
    drv0(AOK, RMMOVQ, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC);
    #1;
    chk("a_wrap_stat", 64'(b0.m_stat), 64'(ADR));
    tick();
    drv0(AOK, MRMOVQ, 64'h0, 64'd504);
    #1;
    chk("a_nowrap", b0.m_valM, 64'h0);
    drv0(HLT, RMMOVQ, 64'hDEAD_DEAD_DEAD_DEAD, 64'h40);
    #1;
    chk("a_hlt_stat",  64'(b0.m_stat), 64'(HLT));
    chk("a_hlt_stall", 64'(b0.m_stall), 64'h0);
    tick();
    drv0(AOK, MRMOVQ, 64'h0, 64'h40);
    #1;
    chk("a_hlt_keep", b0.m_valM, 64'h1122334455667788);
    drv0(INS, MRMOVQ, 64'h0, 64'h40);
    #1;
    chk("a_ins_valM", b0.m_valM, 64'h0);
    chk("a_ins_stat", 64'(b0.m_stat), 64'(INS));
    drv0(AOK, 4'h6, 64'h40, 64'h40);
    #1;
    chk("a_nonmem_valM", b0.m_valM, 64'h0);
    chk("a_nonmem_stat", 64'(b0.m_stat), 64'(AOK));
    drv0(AOK, 4'h1, 64'h0, 64'h0);
    tick();
    chk("a_never_stall", 64'(stall0_seen), 64'h0);

    // ---- three wait states ----
    drv3(AOK, RMMOVQ, 64'h5555_5555_5555_5555, 64'h100);
    #1;
    wait3(n);
    chk("b_pre_cnt", 64'(n), 64'd3);
    tick();
    drv3(AOK, PUSHQ, 64'h0123456789ABCDEF, 64'h100);
    #1;
    chk("b_push_stall0", 64'(b3.m_stall), 64'h1);
    wait3(n);
    chk("b_push_cnt",  64'(n), 64'd3);
    chk("b_push_old",  64'(u3.u_mem.mem[256]), 64'h55);
    chk("b_push_done", 64'(b3.m_stall), 64'h0);
    tick();
    chk("b_push_new", 64'(u3.u_mem.mem[256]), 64'hEF);
    drv3(AOK, MRMOVQ, 64'h0, 64'h100);
    #1;
    wait3(n);
    chk("b_rd_cnt", 64'(n), 64'd3);
    chk("b_rd",     b3.m_valM, 64'h0123456789ABCDEF);
    tick();
    drv3(AOK, MRMOVQ, 64'h0, 64'd600);
    #1;
    chk("b_oor_stall", 64'(b3.m_stall), 64'h0);
    chk("b_oor_stat",  64'(b3.m_stat), 64'(ADR));
    tick();
    chk("b_oor_state", 64'(u3.state), 64'(IDLE));
    drv3(AOK, CALL, 64'hCAFE_BABE_CAFE_BABE, 64'h100);
    #1;
    chk("b_call_stall", 64'(b3.m_stall), 64'h1);
    tick();
    tick();
    chk("b_call_wait", 64'(u3.state), 64'(WAIT));
    rst_n = 1'b0;
    #1;
    chk("b_abort_stall", 64'(b3.m_stall), 64'h0);
    chk("b_abort_state", 64'(u3.state), 64'(IDLE));
    drv3(AOK, 4'h1, 64'h0, 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("b_abort_byte", 64'(u3.u_mem.mem[256]), 64'hEF);
    drv3(AOK, MRMOVQ, 64'h0, 64'h100);
    #1;
    wait3(n);
    chk("b_abort_word", b3.m_valM, 64'h0123456789ABCDEF);
    tick();
    drv3(AOK, 4'h1, 64'h0, 64'h0);

    // ---- four-byte words ----
    drv4(AOK, RMMOVQ, 64'hDEADBEEF, 64'd508);
    #1;
    chk("c_wr_stat", 64'(b4.m_stat), 64'(AOK));
    tick();
    drv4(AOK, POPQ, 64'd508, 64'h0);
    #1;
    chk("c_pop508",      64'(b4.m_valM), 64'hDEADBEEF);
    chk("c_pop508_stat", 64'(b4.m_stat), 64'(AOK));
    drv4(AOK, POPQ, 64'd509, 64'h0);
    #1;
    chk("c_pop509_stat", 64'(b4.m_stat), 64'(ADR));
    chk("c_pop509_valM", 64'(b4.m_valM), 64'h0);
    drv4(AOK, 4'h1, 64'h0, 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_wait.md
MEM_STAGE_WAIT -- requirements
Module: mem_stage_wait

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, byte count of the data array.
REQ-002 SHALL have parameter WORD_BYTES, default 8, bytes per access; DATA_W = 8*WORD_BYTES.
REQ-003 SHALL have parameter WAIT_STATES, default 0, stall cycles inserted before each access completes (0..15).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 M_stat  in  2  status from the execute/memory register.
REQ-008 M_icode  in  4  instruction code.
REQ-009 M_valA  in  64  store data, or the read address for ret/popq.
REQ-010 M_valE  in  64  computed address for rmmovq/mrmovq/pushq/call.
REQ-011 M_dstE, M_dstM  in  4 each  destination registers.
REQ-012 m_icode, m_valE, m_dstE, m_dstM  out  4/64/4/4  pass-throughs of the M_ inputs.
REQ-013 m_valM  out  DATA_W  read data.
REQ-014 m_stat  out  2  resulting status.
REQ-015 m_stall  out  1  high while an access is pending; upstream holds the M_ inputs stable while it is high.

Function
REQ-016 Read ops: icode 5 addresses via M_valE; icodes 9 and B address via M_valA.
REQ-017 Write ops: icodes 4, A and 8 write M_valA[DATA_W-1:0] at M_valE.
REQ-018 Byte order SHALL be little-endian: byte addr holds bits [7:0], and addr+WORD_BYTES-1 holds the top byte.
REQ-019 An access is in range iff addr <= MEM_SIZE-WORD_BYTES, compared in 64 bits with no wrap-around.
REQ-020 An out-of-range access: m_stat=2 (ADR), m_valM=0, no array write.
REQ-021 If M_stat != 0 (AOK), the block SHALL suppress any access, pass m_stat=M_stat, set m_valM=0 and keep m_stall low.
REQ-022 Non-memory icodes: m_stall=0, m_valM=0, m_stat=M_stat.
REQ-023 FSM states: IDLE, WAIT.
REQ-024 In IDLE, a valid memory op with WAIT_STATES>0 SHALL assert m_stall, load cnt=1 and go to WAIT.
REQ-025 In WAIT, m_stall = (cnt != WAIT_STATES).
REQ-026 In WAIT, cnt increments each cycle until cnt == WAIT_STATES, then the state returns to IDLE.
REQ-027 Completion cycle: an access accepted in cycle T completes in cycle T+WAIT_STATES, the first cycle with m_stall low.
REQ-028 In the completion cycle, read data SHALL be valid on m_valM (combinational from the array), and m_stat SHALL be final.
REQ-029 A write SHALL commit only at the rising edge ending the completion cycle.
REQ-030 When WAIT_STATES=0, every access SHALL complete in the cycle it is presented and m_stall SHALL never assert.
REQ-031 An out-of-range access SHALL complete immediately without stalling, regardless of WAIT_STATES.
REQ-032 A read that immediately follows a write to the same address SHALL return the new data.
REQ-033 Pass-through outputs SHALL be combinational in every state.

Reset
REQ-034 While rst_n=0: state=IDLE, cnt=0, m_stall=0, m_valM=0, m_stat=M_stat.
REQ-035 Reset SHALL NOT clear the array contents.
REQ-036 Reset asserted during WAIT SHALL abort the access; the pending write SHALL never commit.

Structure
REQ-037 Package y86_pkg SHALL hold the icode constants (RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B).
REQ-038 y86_pkg SHALL hold the stat codes (AOK=0, HLT=1, ADR=2, INS=3) and the FSM state enum.
REQ-039 Sub-module dmem_array (byte array, MEM_SIZE x 8, little-endian WORD_BYTES port, one write port, one combinational read port) SHALL be instantiated once.

Verification
REQ-040 WAIT_STATES=0: rmmovq 0x1122334455667788 to 0x40, then mrmovq 0x40 -> m_valM=0x1122334455667788, byte 0x40 = 0x88, m_stall never high.
REQ-041 WAIT_STATES=3: pushq at 0x100 -> m_stall high for exactly 3 cycles; the write becomes visible only after the 4th edge.
REQ-042 mrmovq at 505 (MEM_SIZE=512) -> m_stat=2, m_valM=0, no stall; an address of 0xFFFFFFFFFFFFFFFC also gives m_stat=2, with no wrap.
REQ-043 rmmovq with M_stat=1 -> array unchanged, m_stat=1.
REQ-044 WAIT_STATES=3: rst_n pulsed low during WAIT of a call -> target bytes unchanged; state returns to IDLE and m_stall=0 asynchronously.
REQ-045 WORD_BYTES=4: popq at 508 -> valid read; popq at 509 -> m_stat=2.
